// File: rtl/ctrl_decode_stage.sv
// Registered instruction-decode control stage with load-use bubble insertion and a sticky HALTED state.
// Optional feature macro: CTRL_OAM_EN enables the OAMW opcode and drives oam_write.
module ctrl_decode_stage #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              branch,
    output logic              jump,
    output logic              mem_to_reg,
    output logic              sign_ext_sel,
    output logic              reg_rt_src,
    output logic              reg_write,
    output logic              mem_write,
    output logic              oam_write,
    output logic              mem_read,
    output logic              halt,
    output logic [1:0]        alu_src,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic              illegal,
    output logic              halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_to_reg;
        logic       sign_ext_sel;
        logic       reg_rt_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       halt;
        logic [1:0] alu_src;
        logic       illegal;
    } ctrl_t;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs;
    logic [REG_AW-1:0] f_rt;
    ctrl_t             ctrl_dec;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic              lw_pend_q, lw_pend_d;
    logic [REG_AW-1:0] lw_rd_q, lw_rd_d;

    logic              advance;
    logic              hazard;
    logic              accept;

`ifdef CTRL_OAM_EN
    logic              oam_dec;
    logic              oam_write_q, oam_write_d;
`endif

    assign opcode = instr[INSTR_W-1 -: 6];
    assign f_rd   = instr[INSTR_W-7 -: REG_AW];
    assign f_rs   = instr[INSTR_W-7-REG_AW -: REG_AW];
    assign f_rt   = instr[INSTR_W-7-2*REG_AW -: REG_AW];

    // HALT is the all-ones word; opcode 111111 with any zero bit is illegal.
    always_comb begin
        ctrl_dec = '0;
`ifdef CTRL_OAM_EN
        oam_dec  = 1'b0;
`endif
        if (&instr) begin
            ctrl_dec.halt = 1'b1;
        end else begin
            unique case (opcode)
                6'b000000: begin
                    ctrl_dec.reg_write    = 1'b1;
                    ctrl_dec.sign_ext_sel = 1'b1;
                end
                6'b000001: begin
                    ctrl_dec.reg_write    = 1'b1;
                    ctrl_dec.sign_ext_sel = 1'b1;
                    ctrl_dec.alu_src      = 2'b01;
                end
                6'b000010, 6'b000011, 6'b001000, 6'b000100: begin
                    ctrl_dec.reg_write = 1'b1;
                end
                6'b000101: begin
                    ctrl_dec.reg_write = 1'b1;
                    ctrl_dec.alu_src   = 2'b01;
                end
                6'b010000, 6'b010001, 6'b010010: begin
                    ctrl_dec.branch       = 1'b1;
                    ctrl_dec.sign_ext_sel = 1'b1;
                    ctrl_dec.alu_src      = 2'b01;
                end
                6'b001100, 6'b001110, 6'b001111: begin
                    ctrl_dec.jump = 1'b1;
                end
                6'b001101: begin
                    ctrl_dec.jump      = 1'b1;
                    ctrl_dec.reg_write = 1'b1;
                end
                6'b100000: begin
                    ctrl_dec.mem_read     = 1'b1;
                    ctrl_dec.mem_to_reg   = 1'b1;
                    ctrl_dec.reg_write    = 1'b1;
                    ctrl_dec.alu_src      = 2'b01;
                    ctrl_dec.sign_ext_sel = 1'b1;
                end
                6'b100001: begin
                    ctrl_dec.mem_write    = 1'b1;
                    ctrl_dec.reg_rt_src   = 1'b1;
                    ctrl_dec.alu_src      = 2'b01;
                    ctrl_dec.sign_ext_sel = 1'b1;
                end
`ifdef CTRL_OAM_EN
                6'b100010: begin
                    oam_dec             = 1'b1;
                    ctrl_dec.reg_rt_src = 1'b1;
                    ctrl_dec.alu_src    = 2'b01;
                end
`endif
                default: begin
                    ctrl_dec.illegal = 1'b1;
                end
            endcase
        end
    end

    assign advance  = ~out_valid_q | out_ready;
    assign hazard   = lw_pend_q & in_valid & ((f_rs == lw_rd_q) | (f_rt == lw_rd_q));
    assign in_ready = ~rst & (state_q == ST_RUN) & ~hazard & ~flush & advance;
    assign accept   = in_valid & in_ready;

    // A stalled hazard holds everything; only an advancing slot turns it into a bubble.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        lw_pend_d   = lw_pend_q;
        lw_rd_d     = lw_rd_q;
`ifdef CTRL_OAM_EN
        oam_write_d = oam_write_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            lw_pend_d   = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = ctrl_dec;
            rd_d        = f_rd;
            rs_d        = f_rs;
            rt_d        = f_rt;
            lw_pend_d   = ctrl_dec.mem_read & (f_rd != '0);
            lw_rd_d     = f_rd;
`ifdef CTRL_OAM_EN
            oam_write_d = oam_dec;
`endif
            if (ctrl_dec.halt) begin
                state_d = ST_HALTED;
            end
        end else if (advance) begin
            out_valid_d = 1'b0;
            if (hazard) begin
                lw_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            lw_pend_q   <= 1'b0;
            lw_rd_q     <= '0;
`ifdef CTRL_OAM_EN
            oam_write_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            lw_pend_q   <= lw_pend_d;
            lw_rd_q     <= lw_rd_d;
`ifdef CTRL_OAM_EN
            oam_write_q <= oam_write_d;
`endif
        end
    end

`ifdef CTRL_OAM_EN
    assign oam_write = oam_write_q;
`else
    assign oam_write = 1'b0;
`endif

    assign out_valid    = out_valid_q;
    assign branch       = ctrl_q.branch;
    assign jump         = ctrl_q.jump;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign sign_ext_sel = ctrl_q.sign_ext_sel;
    assign reg_rt_src   = ctrl_q.reg_rt_src;
    assign reg_write    = ctrl_q.reg_write;
    assign mem_write    = ctrl_q.mem_write;
    assign mem_read     = ctrl_q.mem_read;
    assign halt         = ctrl_q.halt;
    assign alu_src      = ctrl_q.alu_src;
    assign illegal      = ctrl_q.illegal;
    assign out_rd       = rd_q;
    assign out_rs       = rs_q;
    assign out_rt       = rt_q;
    assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_ctrl_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic        branch, jump, mem_to_reg, sign_ext_sel, reg_rt_src;
    logic        reg_write, mem_write, oam_write, mem_read, halt;
    logic [1:0]  alu_src;
    logic [4:0]  out_rd, out_rs, out_rt;
    logic        illegal;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    ctrl_decode_stage #(.INSTR_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .branch(branch), .jump(jump), .mem_to_reg(mem_to_reg), .sign_ext_sel(sign_ext_sel),
        .reg_rt_src(reg_rt_src), .reg_write(reg_write), .mem_write(mem_write),
        .oam_write(oam_write), .mem_read(mem_read), .halt(halt), .alu_src(alu_src),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .illegal(illegal), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CTRL_OAM_EN
    localparam bit OAM_EN = 1'b1;
`else
    localparam bit OAM_EN = 1'b0;
`endif

    // Control vector order: branch jump mem_to_reg sign_ext_sel reg_rt_src reg_write
    // mem_write oam_write mem_read halt alu_src[1:0] illegal
    logic [12:0] dut_ctrl;
    assign dut_ctrl = {branch, jump, mem_to_reg, sign_ext_sel, reg_rt_src, reg_write,
                       mem_write, oam_write, mem_read, halt, alu_src, illegal};

    typedef struct packed {
        logic [12:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } exp_t;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'h000};
    endfunction

    // Decode table written from the instruction-set description, by mnemonic class
    function automatic logic [12:0] exp_ctrl(input logic [31:0] w);
        logic [5:0] op;
        logic br, jp, m2r, sx, rts, rw, mw, ow, mr, hl, il;
        logic [1:0] as;
        op = w[31:26];
        {br, jp, m2r, sx, rts, rw, mw, ow, mr, hl, il} = '0;
        as = 2'b00;
        if (w == 32'hFFFF_FFFF) begin
            hl = 1'b1;
        end else if (op == 6'b000000 || op == 6'b000001) begin
            rw = 1'b1; sx = 1'b1; as = (op == 6'b000001) ? 2'b01 : 2'b00;
        end else if (op == 6'b000010 || op == 6'b000011 || op == 6'b001000 || op == 6'b000100) begin
            rw = 1'b1;
        end else if (op == 6'b000101) begin
            rw = 1'b1; as = 2'b01;
        end else if (op == 6'b010000 || op == 6'b010001 || op == 6'b010010) begin
            br = 1'b1; sx = 1'b1; as = 2'b01;
        end else if (op[5:2] == 4'b0011) begin
            jp = 1'b1; rw = (op == 6'b001101);
        end else if (op == 6'b100000) begin
            mr = 1'b1; m2r = 1'b1; rw = 1'b1; as = 2'b01; sx = 1'b1;
        end else if (op == 6'b100001) begin
            mw = 1'b1; rts = 1'b1; as = 2'b01; sx = 1'b1;
        end else if (op == 6'b100010 && OAM_EN) begin
            ow = 1'b1; rts = 1'b1; as = 2'b01;
        end else begin
            il = 1'b1;
        end
        return {br, jp, m2r, sx, rts, rw, mw, ow, mr, hl, as, il};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the output slot is a queue holding at most one expected bundle
    exp_t slot[$];
    bit   m_live  = 1'b0;
    bit   m_fresh = 1'b0;
    bit   m_halted;
    bit   m_pend;
    logic [4:0] m_lw_rd;

    function automatic bit model_hazard();
        return m_pend && in_valid && (instr[20:16] == m_lw_rd || instr[15:11] == m_lw_rd);
    endfunction

    function automatic bit model_in_ready();
        return !rst && !m_halted && !model_hazard() && !flush && (slot.size() == 0 || out_ready);
    endfunction

    always @(posedge clk) begin
        bit   acc;
        bit   hz;
        bit   slot_moves;
        exp_t e;
        if (rst) begin
            slot.delete();
            m_halted = 1'b0;
            m_pend   = 1'b0;
            m_lw_rd  = 5'd0;
            m_live   = 1'b1;
            m_fresh  = 1'b1;
        end else if (m_live) begin
            hz         = model_hazard();
            acc        = in_valid && model_in_ready();
            slot_moves = (slot.size() == 0) || out_ready;
            if (flush) begin
                slot.delete();
                m_pend = 1'b0;
            end else begin
                if (out_ready && slot.size() != 0) void'(slot.pop_front());
                if (acc) begin
                    e.ctrl = exp_ctrl(instr);
                    e.rd   = instr[25:21];
                    e.rs   = instr[20:16];
                    e.rt   = instr[15:11];
                    slot.push_back(e);
                    m_fresh = 1'b0;
                    m_pend  = (instr[31:26] == 6'b100000) && (instr != 32'hFFFF_FFFF) && (e.rd != 5'd0);
                    m_lw_rd = e.rd;
                    if (instr == 32'hFFFF_FFFF) m_halted = 1'b1;
                end else if (hz && slot_moves) begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("m_in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
            checkOutput("m_out_valid", {31'd0, out_valid}, {31'd0, slot.size() != 0});
            checkOutput("m_halted", {31'd0, halted}, {31'd0, m_halted});
            if (slot.size() != 0) begin
                checkOutput("m_ctrl", {19'd0, dut_ctrl}, {19'd0, slot[0].ctrl});
                checkOutput("m_fields", {17'd0, out_rd, out_rs, out_rt},
                            {17'd0, slot[0].rd, slot[0].rs, slot[0].rt});
            end else if (m_fresh) begin
                checkOutput("m_reset_ctrl", {19'd0, dut_ctrl}, 32'd0);
                checkOutput("m_reset_fields", {17'd0, out_rd, out_rs, out_rt}, 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] w, input logic v, input logic ordy, input logic fl);
        instr     = w;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] OP_ADD = 6'b000000, OP_ADDI = 6'b000001, OP_SUB = 6'b000010;
    localparam logic [5:0] OP_XOR = 6'b001000, OP_LW = 6'b100000, OP_OAMW = 6'b100010;

    logic [5:0] pool [18];

    initial begin
        pool = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001000, 6'b000100,
                 6'b000101, 6'b010000, 6'b010001, 6'b010010, 6'b001100, 6'b001101,
                 6'b001111, 6'b100000, 6'b100001, 6'b100010, 6'b111110, 6'b100000};
        rst = 1'b1;
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_ctrl", {19'd0, dut_ctrl}, 32'd0);
        rst = 1'b0;

        $display("[TB] back-to-back ALU ops");
        applyStimulus(mk(OP_ADD, 5'd1, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0);
        checkOutput("add_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("add_ctrl", {19'd0, dut_ctrl}, {19'd0, 13'b0001_0100_0000_0});
        applyStimulus(mk(OP_ADDI, 5'd2, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("addi_ctrl", {19'd0, dut_ctrl}, {19'd0, 13'b0001_0100_0001_0});
        applyStimulus(mk(OP_SUB, 5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("sub_ctrl", {19'd0, dut_ctrl}, {19'd0, 13'b0000_0100_0000_0});
        checkOutput("sub_valid", {31'd0, out_valid}, 32'd1);

        $display("[TB] load-use hazard");
        applyStimulus(mk(OP_LW, 5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("lw_ctrl", {19'd0, dut_ctrl}, {19'd0, 13'b0011_0100_1001_0});
        applyStimulus(mk(OP_ADD, 5'd4, 5'd3, 5'd0), 1'b1, 1'b1, 1'b0);
        checkOutput("hazard_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("bubble_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_bubble_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("after_bubble_rs", {27'd0, out_rs}, 32'd3);
        applyStimulus(mk(OP_LW, 5'd0, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(mk(OP_ADD, 5'd4, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        checkOutput("lw_r0_no_hazard", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("lw_r0_add_valid", {31'd0, out_valid}, 32'd1);

        $display("[TB] downstream stall");
        applyStimulus(mk(OP_XOR, 5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_hold_rd", {27'd0, out_rd}, 32'd4);
            checkOutput("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        applyStimulus(mk(OP_XOR, 5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        checkOutput("drain_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("drain_rd", {27'd0, out_rd}, 32'd5);

        $display("[TB] illegal and OAM opcodes");
        applyStimulus(mk(6'b111110, 5'd1, 5'd1, 5'd1), 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("illegal_ctrl", {19'd0, dut_ctrl}, 32'd1);
        checkOutput("illegal_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(mk(OP_OAMW, 5'd0, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("oamw_oam_write", {31'd0, oam_write}, {31'd0, OAM_EN});
        checkOutput("oamw_illegal", {31'd0, illegal}, {31'd0, !OAM_EN});

        $display("[TB] flush and halt");
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_halt_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_halt_halted", {31'd0, halted}, 32'd0);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("halt_bit", {31'd0, halt}, 32'd1);
        checkOutput("halted_rise", {31'd0, halted}, 32'd1);
        applyStimulus(mk(OP_ADD, 5'd1, 5'd1, 5'd1), 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("halted_flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("halted_flush_stays", {31'd0, halted}, 32'd1);
        applyStimulus(mk(OP_ADD, 5'd1, 5'd1, 5'd1), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("halted_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        rst = 1'b1;
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(mk(OP_ADD, 5'd1, 5'd1, 5'd1), 1'b1, 1'b1, 1'b0);
        checkOutput("rst_clears_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_run_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            w = mk(pool[$urandom_range(0, 17)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            w[10:0] = 11'($urandom);
            if ($urandom_range(0, 49) == 0) w = 32'hFFFF_FFFF;
            rst = (m_halted && $urandom_range(0, 7) == 0) || ($urandom_range(0, 199) == 0);
            applyStimulus(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 19) == 0));
            tick();
        end
        rst = 1'b0;
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
